uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmit line between two byte requesters (game logic, debug/status).
//  Round-robin grants one byte at a time; serialises it 8N1 on the 16x oversampling tick
//  from the baud tick generator (DVSR=651 instance). Sits between requesters and the board TX pin.
// PARAMETERS
//  DBIT     8   data bits per frame, LSB first
//  SB_TICK  16  oversampling ticks in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)
// PORTS
//  clk      in  1     system clock
//  reset    in  1     asynchronous, active-high reset
//  s_tick   in  1     one-cycle pulse, 16 per bit period (baud tick generator output)
//  req0     in  1     requester 0 has a byte; hold high with din0 stable until gnt0
//  din0     in  DBIT  requester 0 data
//  gnt0     out 1     one-cycle pulse: din0 captured
//  req1     in  1     requester 1 has a byte (same rules)
//  din1     in  DBIT  requester 1 data
//  gnt1     out 1     one-cycle pulse: din1 captured
//  tx       out 1     serial line, idle high
//  busy     out 1     high from the cycle after a grant until the frame ends
//  owner    out 1     requester whose byte is on the line; valid while busy
//  tx_done  out 1     one-cycle pulse when the stop bit completes
// BEHAVIOUR
//  - Reset (async, any state, mid-frame included): tx=1, busy=0, gnt0=gnt1=0, tx_done=0,
//    owner=0, state=IDLE, counters=0, priority pointer favours req0. A partial frame is dropped.
//  - All outputs are registered. FSM states: IDLE, START, DATA, STOP.
//  - IDLE: tx=1. If exactly one req is high, grant it. If both are high, grant the one not
//    served last (pointer). Grant cycle: latch din into shift reg, set owner, pulse gnt,
//    s=0, n=0, go START. Latency from req high in IDLE to gnt high = 1 clk.
//  - Requests while busy are ignored. No gnt is issued; requesters keep req high.
//    A req dropped before gnt produces no frame. s_tick is ignored in IDLE.
//  - START: tx=0. On s_tick: if s==15 then s=0, go DATA, else s++.
//  - DATA: tx=shift[0]. On s_tick at s==15: shift>>=1, s=0. If n==DBIT-1 go STOP, else n++.
//  - STOP: tx=1. On s_tick at s==SB_TICK-1: pulse tx_done, toggle pointer to favour the
//    other requester, go IDLE. busy drops in the same cycle tx_done rises.
//  - Width rules: s is 5 bits (supports SB_TICK<=32). n is clog2(DBIT) bits. Counters never wrap
//    outside their terminal compare.
//  - Start bit timing is measured from the first s_tick after the grant. Up to one tick period
//    of start jitter is accepted.
//  - Back-to-back: the earliest next grant is the cycle after tx_done. Gap between frames is
//    1 clk of idle-high.
//  - tx_done and gnt never coincide in the same cycle. s_tick coinciding with a grant is not
//    counted.
// STRUCTURE
//  - Shared package uart_pkg: state encoding (IDLE/START/DATA/STOP), OVERSAMPLE=16,
//    default DBIT/SB_TICK.
//  - Sub-module uart_tx_core (START/DATA/STOP shifter with a start/data load interface and
//    done output).
//  - This file holds the IDLE arbiter, the pointer and owner logic, and instantiates the core.
// TESTING  (bench drives s_tick every 4 clks for speed; frame = 10 bits x 16 ticks)
//  1. Only req0, din0=8'hA5 -> gnt0 one clk later. tx = 0, then 1,0,1,0,0,1,0,1, then 1.
//     Each bit is 16 ticks. tx_done fires, owner=0.
//  2. req0 and req1 both high from reset, din0=8'h11, din1=8'h22 -> 8'h11 sent first, then 8'h22.
//     gnt1 arrives the clk after tx_done. Repeat both -> order 0,1,0,1.
//  3. req1 raised mid-frame of req0 -> no gnt1 until tx_done. Then gnt1 next clk; 1-clk idle gap.
//  4. Assert reset in DATA bit 3 -> tx=1, busy=0 immediately. After release, a new req0 8'h3C
//     sends a clean frame.
//  5. SB_TICK=32, din0=8'hFF -> stop-high lasts 32 ticks before tx_done. No s_tick for 100 clks
//     in START -> tx holds 0 and the FSM does not advance.
//  6. req0 pulsed high one clk while busy and dropped -> no gnt0 and no extra frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: frame FSM encoding and default frame geometry.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned SW          = 5;
  localparam int unsigned DBIT_DEF    = 8;
  localparam int unsigned SB_TICK_DEF = 16;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1-style frame serialiser: takes a byte on load while idle, shifts it out LSB first
// on the 16x oversampling tick and pulses done when the stop bit completes.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = DBIT_DEF,
  parameter int unsigned SB_TICK = SB_TICK_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            load,
  input  logic [DBIT-1:0] load_data,
  output logic            tx,
  output logic            busy,
  output logic            done
);

  localparam int unsigned   NW        = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0] S_LAST_OS = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_LAST_SB = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

  uart_state_e     state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          shift_d = load_data;
          s_d     = '0;
          n_d     = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_LAST_OS) begin
            s_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST_OS) begin
            s_d     = '0;
            shift_d = shift_q >> 1;
            if (n_q == N_LAST) state_d = ST_STOP;
            else               n_d     = n_q + NW'(1);
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_LAST_SB) begin
            s_d     = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level and busy follow the next state so they change on the same edge as the FSM.
    busy_d = (state_d != ST_IDLE);
    unique case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin front end for a single UART transmitter: grants one byte
// per frame, tracks the owner of the frame on the line and feeds the serialiser core.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = DBIT_DEF,
  parameter int unsigned SB_TICK = SB_TICK_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            req0,
  input  logic [DBIT-1:0] din0,
  output logic            gnt0,
  input  logic            req1,
  input  logic [DBIT-1:0] din1,
  output logic            gnt1,
  output logic            tx,
  output logic            busy,
  output logic            owner,
  output logic            tx_done
);

  logic            gnt0_q, gnt0_d;
  logic            gnt1_q, gnt1_d;
  logic            owner_q, owner_d;
  logic            ptr_q, ptr_d;
  logic            load_c;
  logic            pick_c;
  logic [DBIT-1:0] load_data_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // The pointer flips on the done cycle itself, so a grant in that same cycle already
  // favours the requester that was not just served.
  always_comb begin
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    owner_d     = owner_q;
    load_c      = 1'b0;
    pick_c      = 1'b0;
    load_data_c = din0;
    ptr_d       = tx_done ? ~owner_q : ptr_q;
    if (!busy && (req0 || req1)) begin
      pick_c      = (req0 && req1) ? ptr_d : req1;
      load_c      = 1'b1;
      owner_d     = pick_c;
      gnt0_d      = ~pick_c;
      gnt1_d      = pick_c;
      load_data_c = pick_c ? din1 : din0;
    end
  end

  uart_tx_core #(
    .DBIT    (DBIT),
    .SB_TICK (SB_TICK)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .s_tick    (s_tick),
    .load      (load_c),
    .load_data (load_data_c),
    .tx        (tx),
    .busy      (busy),
    .done      (tx_done)
  );

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: expected frames are queued when a request is driven and a line monitor
// decodes each frame off tx and compares it against the queue head.
module tb_uart_tx_arbiter;

  typedef struct packed {
    logic [7:0] data;
    logic       owner;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       req0, req1;
  logic [7:0] din0, din1;
  logic       gnt0, gnt1, tx_a, busy_a, owner_a, done_a;
  logic       reqb0, reqb1;
  logic [7:0] dinb0, dinb1;
  logic       gntb0, gntb1, tx_b, busy_b, owner_b, done_b;

  int   compared   = 0;
  int   mismatched = 0;
  bit   tick_en    = 1'b0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DBIT(8), .SB_TICK(16)) dut_a (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .req0(req0), .din0(din0), .gnt0(gnt0),
    .req1(req1), .din1(din1), .gnt1(gnt1),
    .tx(tx_a), .busy(busy_a), .owner(owner_a), .tx_done(done_a)
  );

  uart_tx_arbiter #(.DBIT(8), .SB_TICK(32)) dut_b (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .req0(reqb0), .din0(dinb0), .gnt0(gntb0),
    .req1(reqb1), .din1(dinb1), .gnt1(gntb1),
    .tx(tx_b), .busy(busy_b), .owner(owner_b), .tx_done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input int dut, input logic [7:0] data, input logic own);
    exp_t e;
    e.data  = data;
    e.owner = own;
    if (dut == 0) q_a.push_back(e);
    else          q_b.push_back(e);
  endtask

  // One s_tick every 4 clocks while enabled, driven away from the sampling edge.
  int unsigned tcnt = 0;
  initial begin
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt++;
      s_tick = tick_en && ((tcnt % 4) == 0);
    end
  end

  // Frame monitor for both instances: mid-bit sampling counted from the falling start edge.
  logic        tx_w [2];
  logic        done_w [2];
  logic        busy_w [2];
  logic        owner_w [2];
  assign tx_w[0] = tx_a;    assign tx_w[1] = tx_b;
  assign done_w[0] = done_a; assign done_w[1] = done_b;
  assign busy_w[0] = busy_a; assign busy_w[1] = busy_b;
  assign owner_w[0] = owner_a; assign owner_w[1] = owner_b;

  int unsigned m_cnt [2];
  bit          m_act [2];
  logic [7:0]  m_data [2];
  exp_t        m_exp [2];
  logic        m_prev [2];
  logic        m_tk;
  int unsigned m_last;
  int unsigned m_bit;
  int          m_qsz;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_prev[i] = 1'b1;
      m_act[i]  = 1'b0;
      m_cnt[i]  = 0;
    end
    forever begin
      @(posedge clk);
      m_tk = s_tick;
      #1;
      for (int i = 0; i < 2; i++) begin
        m_last = 16 * 9 + ((i == 0) ? 16 : 32);
        if (reset) begin
          m_act[i] = 1'b0;
        end else if (!m_act[i]) begin
          if (m_prev[i] && !tx_w[i]) begin
            m_act[i]  = 1'b1;
            m_cnt[i]  = 0;
            m_data[i] = '0;
            m_qsz = (i == 0) ? q_a.size() : q_b.size();
            chk("mon_frame_expected", 32'(m_qsz != 0), 32'd1);
            if (m_qsz == 0)  m_exp[i] = 'x;
            else if (i == 0) m_exp[i] = q_a.pop_front();
            else             m_exp[i] = q_b.pop_front();
            chk("mon_owner", 32'(owner_w[i]), 32'(m_exp[i].owner));
            chk("mon_busy_in_frame", 32'(busy_w[i]), 32'd1);
          end
        end else begin
          if (m_tk) begin
            m_cnt[i]++;
            if ((m_cnt[i] % 16) == 8 && m_cnt[i] < 16 * 10) begin
              m_bit = m_cnt[i] / 16;
              if (m_bit == 0)      chk("mon_start_bit", 32'(tx_w[i]), 32'd0);
              else if (m_bit <= 8) m_data[i][3'(m_bit - 1)] = tx_w[i];
              else                 chk("mon_stop_bit", 32'(tx_w[i]), 32'd1);
            end
            if (m_cnt[i] >= 16 * 9 && m_cnt[i] < m_last)
              chk("mon_stop_high", 32'(tx_w[i]), 32'd1);
          end
          if (done_w[i]) begin
            chk("mon_done_tick_count", 32'(m_cnt[i]), 32'(m_last));
            chk("mon_frame_data", 32'(m_data[i]), 32'(m_exp[i].data));
            chk("mon_busy_at_done", 32'(busy_w[i]), 32'd0);
            m_act[i] = 1'b0;
          end else if (m_cnt[i] > m_last) begin
            chk("mon_done_missing", 32'(done_w[i]), 32'd1);
            m_act[i] = 1'b0;
          end
        end
        m_prev[i] = tx_w[i];
      end
    end
  end

  task automatic wait_grant_a(input int budget, output int which, output logic after_done,
                              output logic prev_hi);
    logic pd, pt;
    pd = 1'b0; pt = 1'b1;
    which = -1; after_done = 1'b0; prev_hi = 1'b0;
    for (int c = 0; c < budget && which < 0; c++) begin
      @(posedge clk); #1;
      if (gnt0 || gnt1) begin
        which      = gnt1 ? 1 : 0;
        after_done = pd;
        prev_hi    = pt;
        chk("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
      end
      pd = done_a;
      pt = tx_a;
    end
  endtask

  task automatic wait_done(input int dut, input int budget, output int gnts, output logic seen);
    gnts = 0; seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(posedge clk); #1;
      if (dut == 0) begin
        gnts += int'(gnt0) + int'(gnt1);
        seen  = done_a;
      end else begin
        gnts += int'(gntb0) + int'(gntb1);
        seen  = done_b;
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   which;
    int   g;
    logic ad, ph, seen;

    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; din0 = '0; din1 = '0;
    reqb0 = 1'b0; reqb1 = 1'b0; dinb0 = '0; dinb1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_tx_done", 32'(done_a), 32'd0);
    chk("rst_owner", 32'(owner_a), 32'd0);
    chk("rst_tx_b", 32'(tx_b), 32'd1);
    @(negedge clk);
    reset   = 1'b0;
    tick_en = 1'b1;

    // Single requester, 8'hA5
    @(negedge clk);
    req0 = 1'b1; din0 = 8'hA5; push_exp(0, 8'hA5, 1'b0);
    wait_grant_a(1, which, ad, ph);
    chk("t1_gnt0_latency", 32'(which), 32'd0);
    @(negedge clk);
    req0 = 1'b0;
    @(posedge clk); #1;
    chk("t1_busy", 32'(busy_a), 32'd1);
    chk("t1_owner", 32'(owner_a), 32'd0);
    chk("t1_gnt_one_cycle", 32'(gnt0), 32'd0);
    wait_done(0, 800, g, seen);
    chk("t1_done_seen", 32'(seen), 32'd1);
    chk("t1_owner_at_done", 32'(owner_a), 32'd0);

    // Both requesting from reset: strict alternation 0,1,0,1
    @(negedge clk);
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; din0 = 8'h11; din1 = 8'h22;
    push_exp(0, 8'h11, 1'b0); push_exp(0, 8'h22, 1'b1);
    push_exp(0, 8'h11, 1'b0); push_exp(0, 8'h22, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    wait_grant_a(1, which, ad, ph);
    chk("t2_first_owner", 32'(which), 32'd0);
    for (int k = 1; k < 4; k++) begin
      wait_grant_a(800, which, ad, ph);
      chk("t2_rr_order", 32'(which), 32'(k % 2));
      chk("t2_gnt_after_done", 32'(ad), 32'd1);
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    wait_done(0, 800, g, seen);
    chk("t2_last_done", 32'(seen), 32'd1);

    // req1 raised mid-frame waits for tx_done, then a 1-clk idle gap
    @(negedge clk);
    req0 = 1'b1; din0 = 8'h33;
    push_exp(0, 8'h33, 1'b0); push_exp(0, 8'hC4, 1'b1);
    wait_grant_a(1, which, ad, ph);
    chk("t3_gnt0", 32'(which), 32'd0);
    @(negedge clk);
    req0 = 1'b0;
    repeat (200) @(negedge clk);
    req1 = 1'b1; din1 = 8'hC4;
    wait_grant_a(800, which, ad, ph);
    chk("t3_gnt1_owner", 32'(which), 32'd1);
    chk("t3_gnt1_after_done", 32'(ad), 32'd1);
    chk("t3_gap_idle_high", 32'(ph), 32'd1);
    chk("t3_start_after_gap", 32'(tx_a), 32'd0);
    @(negedge clk);
    req1 = 1'b0;
    wait_done(0, 800, g, seen);
    chk("t3_done", 32'(seen), 32'd1);

    // Reset during data bit 3 drops the frame, then a clean 8'h3C frame
    @(negedge clk);
    req0 = 1'b1; din0 = 8'h5A; push_exp(0, 8'h5A, 1'b0);
    wait_grant_a(1, which, ad, ph);
    chk("t4_gnt0", 32'(which), 32'd0);
    @(negedge clk);
    req0 = 1'b0;
    repeat (290) @(negedge clk);
    chk("t4_busy_before_reset", 32'(busy_a), 32'd1);
    reset = 1'b1;
    #1;
    chk("t4_async_tx", 32'(tx_a), 32'd1);
    chk("t4_async_busy", 32'(busy_a), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    req0 = 1'b1; din0 = 8'h3C; push_exp(0, 8'h3C, 1'b0);
    wait_grant_a(1, which, ad, ph);
    chk("t4_gnt0_after_reset", 32'(which), 32'd0);
    @(negedge clk);
    req0 = 1'b0;
    wait_done(0, 800, g, seen);
    chk("t4_done", 32'(seen), 32'd1);

    // Two stop bits on instance B; START holds while s_tick is absent
    @(negedge clk);
    tick_en = 1'b0;
    repeat (2) @(negedge clk);
    reqb0 = 1'b1; dinb0 = 8'hFF; push_exp(1, 8'hFF, 1'b0);
    @(posedge clk); #1;
    chk("t5_gntb0", 32'(gntb0), 32'd1);
    @(negedge clk);
    reqb0 = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("t5_start_hold_tx", 32'(tx_b), 32'd0);
    chk("t5_start_hold_busy", 32'(busy_b), 32'd1);
    @(negedge clk);
    tick_en = 1'b1;
    wait_done(1, 1000, g, seen);
    chk("t5_done", 32'(seen), 32'd1);

    // A short req0 pulse while busy earns no grant and no frame
    @(negedge clk);
    req0 = 1'b1; din0 = 8'h77; push_exp(0, 8'h77, 1'b0);
    wait_grant_a(1, which, ad, ph);
    chk("t6_gnt0", 32'(which), 32'd0);
    @(negedge clk);
    req0 = 1'b0;
    repeat (20) @(negedge clk);
    req0 = 1'b1; din0 = 8'hEE;
    @(posedge clk); #1;
    chk("t6_no_gnt_while_busy", 32'(gnt0), 32'd0);
    @(negedge clk);
    req0 = 1'b0;
    wait_done(0, 800, g, seen);
    chk("t6_done", 32'(seen), 32'd1);
    chk("t6_grants_in_frame", 32'(g), 32'd0);
    wait_done(0, 60, g, seen);
    chk("t6_no_extra_grant", 32'(g), 32'd0);
    chk("t6_no_extra_frame", 32'(seen), 32'd0);

    chk("end_queue_a_empty", 32'(q_a.size()), 32'd0);
    chk("end_queue_b_empty", 32'(q_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
